// File: rtl/b16_mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its three neighbours: cpu, host master and SRAM.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface b16_mem_arbiter_if #(
  parameter int l = 16
);
  logic         run_in;
  logic         cpu_run;
  logic [l-1:0] cpu_addr;
  logic         cpu_rd;
  logic [1:0]   cpu_wr;
  logic [l-1:0] cpu_dout;
  logic [l-1:0] cpu_din;
  logic         h_req;
  logic [l-1:0] h_addr;
  logic         h_rd;
  logic [1:0]   h_wr;
  logic [l-1:0] h_wdata;
  logic         h_ack;
  logic [l-1:0] h_rdata;
  logic [l-1:0] mem_addr;
  logic         mem_rd;
  logic [1:0]   mem_wr;
  logic [l-1:0] mem_wdata;
  logic [l-1:0] mem_rdata;

  modport slave (
    input  run_in, cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    input  h_req, h_addr, h_rd, h_wr, h_wdata,
    input  mem_rdata,
    output cpu_run, cpu_din, h_ack, h_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output run_in, cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    output h_req, h_addr, h_rd, h_wr, h_wdata,
    output mem_rdata,
    input  cpu_run, cpu_din, h_ack, h_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/b16_mem_arbiter.sv
// Shares one asynchronous-read SRAM port between the b16 cpu and a secondary host master.
// The cpu owns the bus by default and is frozen (cpu_run low) only while a host access runs.
module b16_mem_arbiter #(
  parameter int l         = 16,
  parameter int HOST_WAIT = 0
) (
  input  logic               clk,
  input  logic               nreset,
  b16_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_HOST = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(HOST_WAIT);

  state_t       state_q, state_d;
  logic [3:0]   wcnt_q, wcnt_d;
  logic         h_ack_q, h_ack_d;
  logic [l-1:0] h_rdata_q, h_rdata_d;
  logic         host_sel;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_CPU;
      wcnt_q    <= 4'd0;
      h_ack_q   <= 1'b0;
      h_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      h_ack_q   <= h_ack_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  // The ACK cycle ignores h_req because the host still presents the request just served.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    h_ack_d   = 1'b0;
    h_rdata_d = h_rdata_q;
    case (state_q)
      ST_CPU: begin
        if (bus.h_req) begin
          state_d = ST_HOST;
          wcnt_d  = WAIT_INIT;
        end
      end
      ST_HOST: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          if (bus.h_rd) begin
            h_rdata_d = bus.mem_rdata;
          end
          h_ack_d = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_CPU;
      end
      default: begin
        state_d = ST_CPU;
      end
    endcase
  end

  assign host_sel = (state_q == ST_HOST);

  // A halted cpu may still present write strobes; gate them so it never writes.
  always_comb begin
    if (host_sel) begin
      bus.cpu_run   = 1'b0;
      bus.mem_addr  = bus.h_addr;
      bus.mem_rd    = bus.h_rd;
      bus.mem_wr    = bus.h_wr;
      bus.mem_wdata = bus.h_wdata;
    end else begin
      bus.cpu_run   = bus.run_in;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_rd    = bus.cpu_rd;
      bus.mem_wr    = bus.cpu_wr & {2{bus.run_in}};
      bus.mem_wdata = bus.cpu_dout;
    end
  end

  assign bus.cpu_din = bus.mem_rdata;
  assign bus.h_ack   = h_ack_q;
  assign bus.h_rdata = h_rdata_q;

endmodule
